dog_draw: RTL and testbench
===========================

Name: dog_draw

Overview:
- Reader side of the dog sprite ROM. Walks the VGA pixel stream and generates the ROM pixel address and frame select (`dog_select`).
- Consumes the 1-cycle-latency ROM `rgb` and overlays the dog sprite on the incoming background stream.
- Contains the intro animation FSM: walk in, sniff, jump into grass, hide, then pulse `done`.
- Sits in the draw chain between the background drawer and the duck drawer.

Parameters:
- DOG_W, 60, sprite width in pixels.
- DOG_H, 44, sprite height in pixels (DOG_W*DOG_H = 2640 words per frame).
- X_START, 0, walk start x (left edge).
- X_STOP, 300, walk end x.
- Y_GROUND, 520, sprite top y while walking/sniffing.
- WALK_STEP, 2, x increment per video frame during WALK.
- ANIM_DIV, 6, video frames per walk-animation frame.
- SNIFF_TICKS, 45, video frames spent in SNIFF.
- JUMP_STEP, 4, y decrement per video frame in JUMP.
- JUMP_TICKS, 20, video frames in JUMP.
- TRANSPARENT, 12'hF0F, key color; pixels of this color are not drawn.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; begins the animation when IDLE
- vga_in_hcount  in  11  horizontal pixel count
- vga_in_vcount  in  11  vertical line count
- vga_in_hsync / vga_in_vsync / vga_in_hblnk / vga_in_vblnk  in  1 each  timing
- vga_in_rgb  in  12  background pixel
- rom_rgb  in  12  ROM data, valid 1 clk after address
- rom_address  out  12  linear sprite address
- dog_select  out  4  ROM frame select, 0..6
- vga_out_hcount / vga_out_vcount  out  11  delayed counts
- vga_out_hsync / vga_out_vsync / vga_out_hblnk / vga_out_vblnk  out  1 each  delayed timing
- vga_out_rgb  out  12  composited pixel
- busy  out  1  high in any state except IDLE
- done  out  1  1-cycle pulse on leaving HIDE

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: all outputs 0, state IDLE, x = X_START, y = Y_GROUND, all counters 0.
- Frame tick: registered rising edge of `vga_in_vblnk`; one-cycle `tick`.
- Pixel pipeline, stage 1 (registered):
  - compute `in_win` = (hcount - x) < DOG_W && (vcount - y) < DOG_H, using unsigned 11-bit differences so that left/above underflows to out-of-window.
  - `rom_address` = (vcount - y)*DOG_W + (hcount - x), truncated to 12 bits; 0 when not `in_win`.
  - Register all timing signals, background rgb and `in_win`.
- Pixel pipeline, stage 2 (registered):
  - `vga_out_rgb` = `rom_rgb` if `in_win`, state draws the dog, and `rom_rgb` != TRANSPARENT; otherwise background rgb.
  - Timing signals: second delay.
- Total latency: 2 clk for every `vga_out_*` signal, with no bubbles.
- State registers (x, y, `dog_select`) update only on `tick`, i.e. during vblank, so there is no tearing mid-frame.
- FSM:
  - IDLE: dog not drawn. On `start`: go to WALK, x = X_START, y = Y_GROUND, `dog_select` = 0.
  - WALK: on each tick, x += WALK_STEP. `anim_cnt` counts 0..ANIM_DIV-1; on wrap, `dog_select` cycles 0,1,2,3,0...
    - When x + WALK_STEP >= X_STOP: clamp x = X_STOP, go to SNIFF, `dog_select` = 4.
  - SNIFF: counts SNIFF_TICKS ticks, then goes to JUMP with `dog_select` = 5.
  - JUMP: on each tick, y -= JUMP_STEP.
    - After JUMP_TICKS/2 ticks, `dog_select` = 6.
    - After JUMP_TICKS ticks, go to HIDE.
  - HIDE: dog not drawn; waits one tick, then goes to IDLE and pulses `done`.
- Frame selects 7..8 are never driven; other drawers own them.
- `start` while busy: ignored.
- `start` coincident with `tick` in IDLE: start is taken, and x/y load with their start values (the tick does not also step).
- Async reset mid-animation: immediate IDLE; the pixel pipeline flushes to zero.

Decomposition:
- Shared package `vga_pkg` holds:
  - dog geometry constants (DOG_W, DOG_H);
  - the dog frame enumeration (`DOG_WALK0`..`DOG_WALK3`, `DOG_SNIFF`, `DOG_JUMP0`, `DOG_JUMP1`);
  - the state enum `dog_state_t` (IDLE, WALK, SNIFF, JUMP, HIDE);
  - the TRANSPARENT default.
- One natural sub-module, `dog_anim_ctl`: FSM plus x/y/`dog_select` registers, driven by `tick`.
- The pixel pipeline stays in `dog_draw`.

Test Plan:
- Reset with `rst_n` = 0 mid-frame -> all outputs 0, `busy` = 0. After release, with no start: `vga_out_rgb` equals `vga_in_rgb` delayed exactly 2 clk.
- `start` then 1 tick -> x = 2, `dog_select` = 0.
  - Pixel at hcount = 3, vcount = 521 -> `rom_address` = 1*60 + 1 = 61 one clk later.
  - With ROM model returning 12'h123 -> `vga_out_rgb` = 12'h123 at +2 clk.
- ROM model returning 12'hF0F inside the window -> background passes unchanged.
  - hcount = x-1 (underflow) and hcount = x+60 -> out of window, address 0.
- Full run with defaults:
  - `dog_select` follows 0,1,2,3 every 6 ticks.
  - SNIFF is entered at tick 150 with x = 300.
  - `dog_select` = 4 for 45 ticks, then 5, then 6 after 10 ticks.
  - y = 520 - 80 = 440 at the end of JUMP.
  - `done` pulses once after the HIDE tick; `busy` then drops to 0.
- `start` pulsed during WALK -> no effect on x/state.
- `rst_n` asserted during JUMP -> state IDLE immediately; a subsequent `start` restarts from x = 0, y = 520.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/sprite definitions: dog geometry, frame ids, animation states.
package vga_pkg;

  localparam int DOG_W = 60;
  localparam int DOG_H = 44;
  localparam logic [11:0] DOG_TRANSPARENT = 12'hF0F;

  // ROM frame selects owned by the dog; 7..8 belong to other drawers.
  typedef enum logic [3:0] {
    DOG_WALK0 = 4'd0,
    DOG_WALK1 = 4'd1,
    DOG_WALK2 = 4'd2,
    DOG_WALK3 = 4'd3,
    DOG_SNIFF = 4'd4,
    DOG_JUMP0 = 4'd5,
    DOG_JUMP1 = 4'd6
  } dog_frame_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    SNIFF = 3'd2,
    JUMP  = 3'd3,
    HIDE  = 3'd4
  } dog_state_t;

  // Timing bundle carried down the pixel pipeline.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_tim_t;

endpackage

// File: rtl/dog_anim_ctl.sv
// Intro animation FSM: walk in, sniff, jump into the grass, hide, pulse done.
// Position and frame select only move on the vblank tick (or on start in IDLE).
module dog_anim_ctl #(
  parameter int X_START     = 0,
  parameter int X_STOP      = 300,
  parameter int Y_GROUND    = 520,
  parameter int WALK_STEP   = 2,
  parameter int ANIM_DIV    = 6,
  parameter int SNIFF_TICKS = 45,
  parameter int JUMP_STEP   = 4,
  parameter int JUMP_TICKS  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        tick,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [3:0]  dog_select,
  output logic        draw,
  output logic        busy,
  output logic        done
);
  import vga_pkg::*;

  dog_state_t state, state_n;
  dog_frame_t sel, sel_n;
  logic [10:0] x_n, y_n;
  logic [7:0]  anim, anim_n;
  logic [7:0]  cnt, cnt_n;
  logic        done_n;

  assign dog_select = sel;
  assign busy       = (state != IDLE);
  assign draw       = (state == WALK) || (state == SNIFF) || (state == JUMP);

  // State and sprite-position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= 11'(X_START);
      y     <= 11'(Y_GROUND);
      sel   <= DOG_WALK0;
      anim  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      sel   <= sel_n;
      anim  <= anim_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  // Next-state logic; start in IDLE wins over a coincident tick
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    sel_n   = sel;
    anim_n  = anim;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = WALK;
        x_n     = 11'(X_START);
        y_n     = 11'(Y_GROUND);
        sel_n   = DOG_WALK0;
        anim_n  = '0;
        cnt_n   = '0;
      end
      WALK: if (tick) begin
        if (12'(x) + 12'(WALK_STEP) >= 12'(X_STOP)) begin
          x_n     = 11'(X_STOP);
          state_n = SNIFF;
          sel_n   = DOG_SNIFF;
          cnt_n   = '0;
        end else begin
          x_n = x + 11'(WALK_STEP);
          if (anim == 8'(ANIM_DIV - 1)) begin
            anim_n = '0;
            sel_n  = (sel == DOG_WALK3) ? DOG_WALK0 : dog_frame_t'(sel + 4'd1);
          end else begin
            anim_n = anim + 8'd1;
          end
        end
      end
      SNIFF: if (tick) begin
        if (cnt == 8'(SNIFF_TICKS - 1)) begin
          state_n = JUMP;
          sel_n   = DOG_JUMP0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      JUMP: if (tick) begin
        y_n = y - 11'(JUMP_STEP);
        if (cnt == 8'(JUMP_TICKS - 1)) begin
          state_n = HIDE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt + 8'd1 == 8'(JUMP_TICKS / 2)) sel_n = DOG_JUMP1;
        end
      end
      HIDE: if (tick) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/dog_draw.sv
// Dog sprite drawer: 2-stage pixel pipeline overlaying ROM pixels on the
// background stream. Stage 1 presents the ROM address; rom_rgb is sampled at
// the following edge by stage 2, so every vga_out_* lags its input by 2 clk.
module dog_draw #(
  parameter int          DOG_W       = vga_pkg::DOG_W,
  parameter int          DOG_H       = vga_pkg::DOG_H,
  parameter int          X_START     = 0,
  parameter int          X_STOP      = 300,
  parameter int          Y_GROUND    = 520,
  parameter int          WALK_STEP   = 2,
  parameter int          ANIM_DIV    = 6,
  parameter int          SNIFF_TICKS = 45,
  parameter int          JUMP_STEP   = 4,
  parameter int          JUMP_TICKS  = 20,
  parameter logic [11:0] TRANSPARENT = vga_pkg::DOG_TRANSPARENT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] vga_in_hcount,
  input  logic [10:0] vga_in_vcount,
  input  logic        vga_in_hsync,
  input  logic        vga_in_vsync,
  input  logic        vga_in_hblnk,
  input  logic        vga_in_vblnk,
  input  logic [11:0] vga_in_rgb,
  input  logic [11:0] rom_rgb,
  output logic [11:0] rom_address,
  output logic [3:0]  dog_select,
  output logic [10:0] vga_out_hcount,
  output logic [10:0] vga_out_vcount,
  output logic        vga_out_hsync,
  output logic        vga_out_vsync,
  output logic        vga_out_hblnk,
  output logic        vga_out_vblnk,
  output logic [11:0] vga_out_rgb,
  output logic        busy,
  output logic        done
);
  import vga_pkg::*;

  logic        vblnk_q, tick;
  logic [10:0] x, y, dx, dy;
  logic        draw, win, win_s1;
  logic [11:0] lin, rgb_s1;
  vga_tim_t    tim_in, tim_s1, tim_s2;

  // Frame tick: one cycle on the registered rising edge of vblank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      vblnk_q <= vga_in_vblnk;
      tick    <= vga_in_vblnk & ~vblnk_q;
    end
  end

  dog_anim_ctl #(
    .X_START(X_START), .X_STOP(X_STOP), .Y_GROUND(Y_GROUND),
    .WALK_STEP(WALK_STEP), .ANIM_DIV(ANIM_DIV), .SNIFF_TICKS(SNIFF_TICKS),
    .JUMP_STEP(JUMP_STEP), .JUMP_TICKS(JUMP_TICKS)
  ) u_ctl (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .x(x), .y(y), .dog_select(dog_select),
    .draw(draw), .busy(busy), .done(done)
  );

  assign tim_in = '{hcount: vga_in_hcount, vcount: vga_in_vcount,
                    hsync: vga_in_hsync, vsync: vga_in_vsync,
                    hblnk: vga_in_hblnk, vblnk: vga_in_vblnk};

  // Unsigned 11-bit offsets: a pixel left of / above the sprite wraps to a
  // large value and falls out of the window without a separate compare.
  assign dx  = vga_in_hcount - x;
  assign dy  = vga_in_vcount - y;
  assign win = (dx < 11'(DOG_W)) && (dy < 11'(DOG_H));
  assign lin = 12'(dy) * 12'(DOG_W) + 12'(dx);

  // Stage 1: window test, ROM address, first timing delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_s1      <= '0;
      rgb_s1      <= '0;
      win_s1      <= 1'b0;
      rom_address <= '0;
    end else begin
      tim_s1      <= tim_in;
      rgb_s1      <= vga_in_rgb;
      win_s1      <= win;
      rom_address <= win ? lin : 12'd0;
    end
  end

  // Stage 2: key-colour composite against background, second timing delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_s2      <= '0;
      vga_out_rgb <= '0;
    end else begin
      tim_s2      <= tim_s1;
      vga_out_rgb <= (win_s1 && draw && rom_rgb != TRANSPARENT) ? rom_rgb : rgb_s1;
    end
  end

  assign vga_out_hcount = tim_s2.hcount;
  assign vga_out_vcount = tim_s2.vcount;
  assign vga_out_hsync  = tim_s2.hsync;
  assign vga_out_vsync  = tim_s2.vsync;
  assign vga_out_hblnk  = tim_s2.hblnk;
  assign vga_out_vblnk  = tim_s2.vblnk;

endmodule

// File: tb/tb_dog_draw.sv
// Bench for dog_draw: table vectors at a known sprite position, a streaming
// pixel scoreboard, and a closed-form model of the whole intro animation.
module tb_dog_draw;

  localparam logic [11:0] KEY = 12'hF0F;
  localparam int W = 60, H = 44;
  localparam int XS = 0, XE = 300, YG = 520, WS = 2, AD = 6;
  localparam int ST = 45, JS = 4, JT = 20;
  localparam int K_SNIFF = (XE - XS) / WS;   // tick that reaches X_STOP
  localparam int K_JUMP  = K_SNIFF + ST;
  localparam int K_HIDE  = K_JUMP + JT;
  localparam int K_IDLE  = K_HIDE + 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [10:0] vga_in_hcount = '0, vga_in_vcount = '0;
  logic vga_in_hsync = 0, vga_in_vsync = 0, vga_in_hblnk = 0, vga_in_vblnk = 0;
  logic [11:0] vga_in_rgb = '0, rom_rgb;
  logic [11:0] rom_address, vga_out_rgb;
  logic [3:0]  dog_select;
  logic [10:0] vga_out_hcount, vga_out_vcount;
  logic vga_out_hsync, vga_out_vsync, vga_out_hblnk, vga_out_vblnk, busy, done;

  dog_draw dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vga_in_hcount(vga_in_hcount), .vga_in_vcount(vga_in_vcount),
    .vga_in_hsync(vga_in_hsync), .vga_in_vsync(vga_in_vsync),
    .vga_in_hblnk(vga_in_hblnk), .vga_in_vblnk(vga_in_vblnk),
    .vga_in_rgb(vga_in_rgb), .rom_rgb(rom_rgb), .rom_address(rom_address),
    .dog_select(dog_select),
    .vga_out_hcount(vga_out_hcount), .vga_out_vcount(vga_out_vcount),
    .vga_out_hsync(vga_out_hsync), .vga_out_vsync(vga_out_vsync),
    .vga_out_hblnk(vga_out_hblnk), .vga_out_vblnk(vga_out_vblnk),
    .vga_out_rgb(vga_out_rgb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM model: either a forced word, or an address-derived pattern with some
  // transparent words mixed in.
  logic        rom_force_en = 1'b0;
  logic [11:0] rom_force = '0;
  function automatic logic [11:0] rom_fn(input logic [11:0] a, input logic fe,
                                         input logic [11:0] fv);
    if (fe) return fv;
    if (a % 12'd7 == 12'd2) return KEY;
    return a ^ 12'h3C3;
  endfunction
  always_comb rom_rgb = rom_fn(rom_address, rom_force_en, rom_force);

  int checks = 0, errors = 0, done_cnt = 0;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference animation state as a function of ticks since start
  int xm, ym, selm;
  bit drawm, busym;
  task automatic model_set(input int k);
    if (k < 0) begin
      xm = XS; ym = YG; selm = 0; drawm = 0; busym = 0;
    end else if (k < K_SNIFF) begin
      xm = XS + WS * k; ym = YG; selm = (k / AD) % 4; drawm = 1; busym = 1;
    end else if (k < K_JUMP) begin
      xm = XE; ym = YG; selm = 4; drawm = 1; busym = 1;
    end else if (k < K_IDLE) begin
      xm = XE; ym = YG - JS * (k - K_JUMP);
      selm = (k - K_JUMP >= JT / 2) ? 6 : 5;
      drawm = (k < K_HIDE); busym = 1;
    end else begin
      xm = XE; ym = YG - JS * JT; selm = 6; drawm = 0; busym = 0;
    end
  endtask

  typedef struct {
    logic [10:0] h, v;
    logic [3:0]  tim;
    logic [11:0] addr, rgb;
  } exp_t;
  exp_t e1;
  bit hv1 = 0;

  // One pixel per clock; checks this pixel's address and last pixel's output
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                     input logic [2:0] sync, input logic vb, input logic st);
    exp_t e;
    int dx, dy;
    bit inw;
    logic [11:0] rv;
    vga_in_hcount = h; vga_in_vcount = v; vga_in_rgb = rgb;
    {vga_in_hsync, vga_in_vsync, vga_in_hblnk} = sync;
    vga_in_vblnk = vb; start = st;
    dx = int'(h) - xm; dy = int'(v) - ym;
    inw = (dx >= 0) && (dx < W) && (dy >= 0) && (dy < H);
    e.h = h; e.v = v; e.tim = {sync, vb};
    e.addr = inw ? 12'(dy * W + dx) : 12'd0;
    rv = rom_fn(e.addr, rom_force_en, rom_force);
    e.rgb = (inw && drawm && rv != KEY) ? rv : rgb;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rom_address", 32'(rom_address), 32'(e.addr));
    if (hv1) begin
      chk("out_rgb", 32'(vga_out_rgb), 32'(e1.rgb));
      chk("out_hcount", 32'(vga_out_hcount), 32'(e1.h));
      chk("out_vcount", 32'(vga_out_vcount), 32'(e1.v));
      chk("out_timing", 32'({vga_out_hsync, vga_out_vsync, vga_out_hblnk, vga_out_vblnk}),
          32'(e1.tim));
    end
    e1 = e; hv1 = 1;
  endtask

  task automatic far_pix(input logic st);
    pix(11'h7FF, 11'h7FF, 12'($urandom), 3'($urandom), 1'b0, st);
  endtask

  // A vblank with far-off pixels; DUT state has moved once this returns
  bit done_seen;
  task automatic frame_tick(input logic st_at_tick);
    pix(11'h7FF, 11'h7FF, 12'($urandom), 3'b011, 1'b1, 1'b0);
    pix(11'h7FF, 11'h7FF, 12'($urandom), 3'b011, 1'b1, st_at_tick);
    done_seen = done;
    pix(11'h7FF, 11'h7FF, 12'($urandom), 3'b000, 1'b0, 1'b0);
  endtask

  task automatic probes();
    pix(11'(xm + 5), 11'(ym + 3), 12'($urandom), 3'($urandom), 1'b0, 1'b0);
    pix(11'(xm - 1), 11'(ym), 12'($urandom), 3'($urandom), 1'b0, 1'b0);
    pix(11'(xm + W), 11'(ym + H - 1), 12'($urandom), 3'($urandom), 1'b0, 1'b0);
    pix(11'(xm + W - 1), 11'(ym + H - 1), 12'($urandom), 3'($urandom), 1'b0, 1'b0);
  endtask

  task automatic state_chk(input int k);
    chk($sformatf("dog_select@%0d", k), 32'(dog_select), 32'(selm));
    chk($sformatf("busy@%0d", k), 32'(busy), 32'(busym));
  endtask

  task automatic near_stream(input int n);
    for (int i = 0; i < n; i++)
      pix(11'(xm - 5 + int'($urandom_range(0, 70))), 11'(ym - 3 + int'($urandom_range(0, 50))),
          12'($urandom), 3'($urandom), 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [10:0] h, v;
    logic [11:0] bg, rom, addr, rgb;
  } vec_t;
  vec_t tv[9];

  initial begin
    // Sprite at x=2, y=520 while these are applied
    tv[0] = '{11'd3,  11'd521, 12'h0AA, 12'h123, 12'd61,   12'h123};
    tv[1] = '{11'd3,  11'd521, 12'h0AB, 12'hF0F, 12'd61,   12'h0AB};
    tv[2] = '{11'd1,  11'd521, 12'h0BB, 12'h123, 12'd0,    12'h0BB};
    tv[3] = '{11'd62, 11'd521, 12'h0CC, 12'h123, 12'd0,    12'h0CC};
    tv[4] = '{11'd61, 11'd563, 12'h0DD, 12'h456, 12'd2639, 12'h456};
    tv[5] = '{11'd2,  11'd519, 12'h0EE, 12'h456, 12'd0,    12'h0EE};
    tv[6] = '{11'd2,  11'd564, 12'h0EF, 12'h456, 12'd0,    12'h0EF};
    tv[7] = '{11'd2,  11'd520, 12'h0F1, 12'h789, 12'd0,    12'h789};
    tv[8] = '{11'd50, 11'd540, 12'h011, 12'h7AB, 12'd1248, 12'h7AB};

    // Reset held while a live-looking stream arrives
    model_set(-1);
    for (int i = 0; i < 4; i++) begin
      vga_in_hcount = 11'($urandom); vga_in_vcount = 11'($urandom);
      vga_in_rgb = 12'($urandom); {vga_in_hsync, vga_in_vsync, vga_in_hblnk} = 3'b111;
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("rst rom_address", 32'(rom_address), 0);
    chk("rst out_rgb", 32'(vga_out_rgb), 0);
    chk("rst out_counts", 32'({vga_out_hcount, vga_out_vcount}), 0);
    chk("rst out_timing", 32'({vga_out_hsync, vga_out_vsync, vga_out_hblnk, vga_out_vblnk}), 0);
    chk("rst dog_select", 32'(dog_select), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    rst_n = 1'b1;

    // Idle: background passes through with exactly 2 clk latency
    for (int i = 0; i < 150; i++)
      pix(11'($urandom_range(0, 120)), 11'($urandom_range(500, 600)), 12'($urandom),
          3'($urandom), 1'b0, 1'b0);
    state_chk(-1);

    // Full intro; start lands on the same cycle as the first tick
    frame_tick(1'b1);
    model_set(0); state_chk(0); probes();
    for (int k = 1; k <= K_IDLE; k++) begin
      frame_tick(1'b0);
      model_set(k);
      chk($sformatf("done@%0d", k), 32'(done_seen), 32'(k == K_IDLE));
      state_chk(k);
      probes();
      if (k == 20) near_stream(60);
      if (k == 75) far_pix(1'b1);   // start while busy must be ignored
    end
    far_pix(1'b0);
    chk("done_count", 32'(done_cnt), 1);

    // Second run, reset asynchronously in the middle of the jump
    far_pix(1'b1);
    model_set(0);
    for (int k = 1; k <= K_JUMP + 5; k++) begin
      frame_tick(1'b0);
      model_set(k);
      state_chk(k);
      probes();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", 32'(busy), 0);
    chk("async dog_select", 32'(dog_select), 0);
    chk("async rom_address", 32'(rom_address), 0);
    chk("async out_rgb", 32'(vga_out_rgb), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hv1 = 0;
    model_set(-1);
    state_chk(-1);

    // Restart from idle: one tick later the sprite sits at x=2, y=520
    far_pix(1'b1);
    model_set(0);
    frame_tick(1'b0);
    model_set(1);
    state_chk(1);
    probes();

    // Hand-derived vectors at x=2, y=520
    for (int i = 0; i < 9; i++) begin
      rom_force_en = 1'b1; rom_force = tv[i].rom;
      vga_in_hcount = tv[i].h; vga_in_vcount = tv[i].v; vga_in_rgb = tv[i].bg;
      @(posedge clk); #1;
      chk($sformatf("tv%0d addr", i), 32'(rom_address), 32'(tv[i].addr));
      vga_in_hcount = 11'h7FF; vga_in_vcount = 11'h7FF; vga_in_rgb = 12'h000;
      @(posedge clk); #1;
      chk($sformatf("tv%0d rgb", i), 32'(vga_out_rgb), 32'(tv[i].rgb));
    end
    rom_force_en = 1'b0;
    hv1 = 0;
    near_stream(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
